// File: rtl/dmem_port_arbiter_pkg.sv
// Shared types for the data-BRAM port B arbiter: owner and state encodings
// plus common bus widths.
package dmem_port_arbiter_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = 4;
    localparam int unsigned WAIT_W = 8;

    localparam logic [BE_W-1:0] WE_NONE = 4'b0000;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CORE = 2'd1,
        OWN_DBG  = 2'd2
    } owner_e;

    typedef enum logic {
        S_CORE = 1'b0,
        S_DBG  = 1'b1
    } state_e;

endpackage

// File: rtl/dmem_port_arbiter_if.sv
// Requester and BRAM port B signals seen by the arbiter; slave is the
// arbiter's view, master is the surrounding core/loader/BRAM environment.
interface dmem_port_arbiter_if
    import dmem_port_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W = 12
);
    logic              core_req;
    logic [BE_W-1:0]   core_we;
    logic [ADDR_W-1:0] core_addr;
    logic [DATA_W-1:0] core_wdata;
    logic              core_stall;
    logic              core_rvalid;
    logic [DATA_W-1:0] core_rdata;

    logic              dbg_req;
    logic              dbg_lock;
    logic [BE_W-1:0]   dbg_we;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_wdata;
    logic              dbg_gnt;
    logic              dbg_rvalid;
    logic [DATA_W-1:0] dbg_rdata;

    logic              enb;
    logic [BE_W-1:0]   web;
    logic [ADDR_W-1:0] addrb;
    logic [DATA_W-1:0] dib;
    logic [DATA_W-1:0] dob;

    modport slave (
        input  core_req, core_we, core_addr, core_wdata,
        output core_stall, core_rvalid, core_rdata,
        input  dbg_req, dbg_lock, dbg_we, dbg_addr, dbg_wdata,
        output dbg_gnt, dbg_rvalid, dbg_rdata,
        output enb, web, addrb, dib,
        input  dob
    );

    modport master (
        output core_req, core_we, core_addr, core_wdata,
        input  core_stall, core_rvalid, core_rdata,
        output dbg_req, dbg_lock, dbg_we, dbg_addr, dbg_wdata,
        input  dbg_gnt, dbg_rvalid, dbg_rdata,
        input  enb, web, addrb, dib,
        output dob
    );

endinterface

// File: rtl/dmem_port_arbiter.sv
// Arbitrates data-BRAM port B between the core load/store path and the debug
// loader, with loader lock bursts, anti-starvation forcing and read return.
module dmem_port_arbiter
    import dmem_port_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W       = 12,
    parameter int unsigned MAX_DBG_WAIT = 8
) (
    input logic                clk,
    input logic                rst_n,
    dmem_port_arbiter_if.slave bus
);

    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_DBG_WAIT);

    state_e            state_q, state_d;
    owner_e            rd_owner_q, rd_owner_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [DATA_W-1:0] core_rdata_q, dbg_rdata_q;

    logic core_req_v, dbg_req_v, force_dbg;
    logic core_gnt, dbg_gnt;

    // Grant decision, next state, starvation counter and read-owner tracking
    always_comb begin
        core_req_v = bus.core_req & rst_n;
        dbg_req_v  = bus.dbg_req & rst_n;
        force_dbg  = dbg_req_v && (wait_cnt_q == WAIT_MAX);
        core_gnt   = 1'b0;
        dbg_gnt    = 1'b0;
        state_d    = state_q;
        wait_cnt_d = '0;
        rd_owner_d = OWN_NONE;

        case (state_q)
            S_CORE: begin
                core_gnt = core_req_v && !force_dbg;
                dbg_gnt  = dbg_req_v && !core_gnt;
                if (dbg_gnt && bus.dbg_lock) begin
                    state_d = S_DBG;
                end
                if (dbg_req_v && !dbg_gnt) begin
                    wait_cnt_d = (wait_cnt_q == WAIT_MAX) ? wait_cnt_q
                                                          : wait_cnt_q + WAIT_W'(1);
                end
            end
            S_DBG: begin
                dbg_gnt = dbg_req_v;
                if (!bus.dbg_lock) begin
                    state_d = S_CORE;
                end
            end
            default: state_d = S_CORE;
        endcase

        if (core_gnt && (bus.core_we == WE_NONE)) begin
            rd_owner_d = OWN_CORE;
        end else if (dbg_gnt && (bus.dbg_we == WE_NONE)) begin
            rd_owner_d = OWN_DBG;
        end
    end

    // Port B mux: zero everything when nobody holds the port
    always_comb begin
        bus.enb   = core_gnt | dbg_gnt;
        bus.web   = WE_NONE;
        bus.addrb = ADDR_W'(0);
        bus.dib   = '0;
        if (dbg_gnt) begin
            bus.web   = bus.dbg_we;
            bus.addrb = bus.dbg_addr;
            bus.dib   = bus.dbg_wdata;
        end else if (core_gnt) begin
            bus.web   = bus.core_we;
            bus.addrb = bus.core_addr;
            bus.dib   = bus.core_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_CORE;
            wait_cnt_q   <= '0;
            rd_owner_q   <= OWN_NONE;
            core_rdata_q <= '0;
            dbg_rdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            rd_owner_q <= rd_owner_d;
            if (rd_owner_q == OWN_CORE) begin
                core_rdata_q <= bus.dob;
            end
            if (rd_owner_q == OWN_DBG) begin
                dbg_rdata_q <= bus.dob;
            end
        end
    end

    // Read data is live from the BRAM in the return cycle, then held
    assign bus.core_stall  = core_req_v & ~core_gnt;
    assign bus.dbg_gnt     = dbg_gnt;
    assign bus.core_rvalid = (rd_owner_q == OWN_CORE);
    assign bus.dbg_rvalid  = (rd_owner_q == OWN_DBG);
    assign bus.core_rdata  = (rd_owner_q == OWN_CORE) ? bus.dob : core_rdata_q;
    assign bus.dbg_rdata   = (rd_owner_q == OWN_DBG)  ? bus.dob : dbg_rdata_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter with a behavioural byte-enabled BRAM
// on port B; inputs change on the falling edge, outputs sampled 1 ns later.
module tb_dmem_port_arbiter;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_pass   = 0;

    dmem_port_arbiter_if #(.ADDR_W(12)) bus ();

    dmem_port_arbiter #(.ADDR_W(12), .MAX_DBG_WAIT(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [0:4095];

    always @(posedge clk) begin
        if (bus.enb) begin
            bus.dob <= mem[bus.addrb];
            for (int b = 0; b < 4; b++) begin
                if (bus.web[b]) mem[bus.addrb][8*b +: 8] <= bus.dib[8*b +: 8];
            end
        end
    end

    task automatic idle();
        bus.core_req = 1'b0; bus.core_we = 4'h0; bus.core_addr = 12'h0; bus.core_wdata = 32'h0;
        bus.dbg_req = 1'b0; bus.dbg_lock = 1'b0; bus.dbg_we = 4'h0; bus.dbg_addr = 12'h0;
        bus.dbg_wdata = 32'h0;
    endtask

    task automatic core_drive(input logic [3:0] we, input logic [11:0] addr, input logic [31:0] wd);
        bus.core_req = 1'b1; bus.core_we = we; bus.core_addr = addr; bus.core_wdata = wd;
    endtask

    task automatic dbg_drive(input logic lock, input logic [3:0] we, input logic [11:0] addr,
                             input logic [31:0] wd);
        bus.dbg_req = 1'b1; bus.dbg_lock = lock; bus.dbg_we = we; bus.dbg_addr = addr;
        bus.dbg_wdata = wd;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle();
        bus.core_req = 1'b1; bus.dbg_req = 1'b1; bus.dbg_lock = 1'b1;
        #1;
        n_checks++; if (bus.enb !== 1'b0) $display("FAIL rst_enb: got %0b want 0", bus.enb); else n_pass++;
        n_checks++; if (bus.web !== 4'h0) $display("FAIL rst_web: got %h want 0", bus.web); else n_pass++;
        n_checks++; if (bus.addrb !== 12'h0) $display("FAIL rst_addrb: got %h want 0", bus.addrb); else n_pass++;
        n_checks++; if (bus.dib !== 32'h0) $display("FAIL rst_dib: got %h want 0", bus.dib); else n_pass++;
        n_checks++; if (bus.core_stall !== 1'b0) $display("FAIL rst_core_stall: got %0b want 0", bus.core_stall); else n_pass++;
        n_checks++; if (bus.dbg_gnt !== 1'b0) $display("FAIL rst_dbg_gnt: got %0b want 0", bus.dbg_gnt); else n_pass++;
        n_checks++; if (bus.core_rvalid !== 1'b0) $display("FAIL rst_core_rvalid: got %0b want 0", bus.core_rvalid); else n_pass++;
        n_checks++; if (bus.dbg_rvalid !== 1'b0) $display("FAIL rst_dbg_rvalid: got %0b want 0", bus.dbg_rvalid); else n_pass++;
        n_checks++; if (bus.core_rdata !== 32'h0) $display("FAIL rst_core_rdata: got %h want 0", bus.core_rdata); else n_pass++;
        n_checks++; if (bus.dbg_rdata !== 32'h0) $display("FAIL rst_dbg_rdata: got %h want 0", bus.dbg_rdata); else n_pass++;
        @(negedge clk); idle();
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_core_only();
        @(negedge clk); core_drive(4'hF, 12'd5, 32'hDEADBEEF); #1;
        n_checks++; if (bus.enb !== 1'b1) $display("FAIL core_wr_enb: got %0b want 1", bus.enb); else n_pass++;
        n_checks++; if (bus.web !== 4'hF) $display("FAIL core_wr_web: got %h want f", bus.web); else n_pass++;
        n_checks++; if (bus.addrb !== 12'd5) $display("FAIL core_wr_addrb: got %h want 5", bus.addrb); else n_pass++;
        n_checks++; if (bus.dib !== 32'hDEADBEEF) $display("FAIL core_wr_dib: got %h want deadbeef", bus.dib); else n_pass++;
        n_checks++; if (bus.core_stall !== 1'b0) $display("FAIL core_wr_stall: got %0b want 0", bus.core_stall); else n_pass++;
        @(negedge clk); core_drive(4'h0, 12'd5, 32'h0); #1;
        n_checks++; if (bus.core_rvalid !== 1'b0) $display("FAIL core_wr_no_rvalid: got %0b want 0", bus.core_rvalid); else n_pass++;
        n_checks++; if (bus.web !== 4'h0) $display("FAIL core_rd_web: got %h want 0", bus.web); else n_pass++;
        n_checks++; if (bus.enb !== 1'b1) $display("FAIL core_rd_enb: got %0b want 1", bus.enb); else n_pass++;
        n_checks++; if (bus.core_stall !== 1'b0) $display("FAIL core_rd_stall: got %0b want 0", bus.core_stall); else n_pass++;
        @(negedge clk); idle(); #1;
        n_checks++; if (bus.core_rvalid !== 1'b1) $display("FAIL core_rd_rvalid: got %0b want 1", bus.core_rvalid); else n_pass++;
        n_checks++; if (bus.core_rdata !== 32'hDEADBEEF) $display("FAIL core_rd_rdata: got %h want deadbeef", bus.core_rdata); else n_pass++;
        n_checks++; if (bus.dbg_rvalid !== 1'b0) $display("FAIL core_rd_dbg_rvalid: got %0b want 0", bus.dbg_rvalid); else n_pass++;
        @(negedge clk); #1;
        n_checks++; if (bus.core_rvalid !== 1'b0) $display("FAIL core_rvalid_one_cycle: got %0b want 0", bus.core_rvalid); else n_pass++;
        n_checks++; if (bus.core_rdata !== 32'hDEADBEEF) $display("FAIL core_rdata_hold: got %h want deadbeef", bus.core_rdata); else n_pass++;
    endtask

    task automatic test_contention();
        for (int i = 0; i <= 8; i++) begin
            @(negedge clk);
            core_drive(4'hF, 12'd7, 32'h7777_0000 + i);
            dbg_drive(1'b0, 4'h0, 12'd5, 32'h0);
            #1;
            n_checks++; if (bus.dbg_gnt !== (i == 8)) $display("FAIL cont_dbg_gnt c%0d: got %0b want %0b", i, bus.dbg_gnt, (i == 8)); else n_pass++;
            n_checks++; if (bus.core_stall !== (i == 8)) $display("FAIL cont_core_stall c%0d: got %0b want %0b", i, bus.core_stall, (i == 8)); else n_pass++;
            if (i == 8) begin
                n_checks++; if (bus.addrb !== 12'd5) $display("FAIL cont_forced_addrb: got %h want 5", bus.addrb); else n_pass++;
                n_checks++; if (bus.web !== 4'h0) $display("FAIL cont_forced_web: got %h want 0", bus.web); else n_pass++;
            end
        end
        @(negedge clk); #1;
        n_checks++; if (bus.dbg_gnt !== 1'b0) $display("FAIL cont_wait_cleared_gnt: got %0b want 0", bus.dbg_gnt); else n_pass++;
        n_checks++; if (bus.core_stall !== 1'b0) $display("FAIL cont_wait_cleared_stall: got %0b want 0", bus.core_stall); else n_pass++;
        n_checks++; if (bus.dbg_rvalid !== 1'b1) $display("FAIL cont_dbg_rvalid: got %0b want 1", bus.dbg_rvalid); else n_pass++;
        n_checks++; if (bus.dbg_rdata !== 32'hDEADBEEF) $display("FAIL cont_dbg_rdata: got %h want deadbeef", bus.dbg_rdata); else n_pass++;
        @(negedge clk); idle(); #1;
        n_checks++; if (bus.dbg_rvalid !== 1'b0) $display("FAIL cont_dbg_rvalid_drop: got %0b want 0", bus.dbg_rvalid); else n_pass++;
    endtask

    task automatic test_lock_burst();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            core_drive(4'hF, 12'd7, 32'h0);
            dbg_drive(1'b1, 4'hF, 12'd0, 32'hA000_0000);
        end
        for (int b = 0; b < 4; b++) begin
            @(negedge clk);
            core_drive(4'hF, 12'd7, 32'h0);
            dbg_drive(1'b1, 4'hF, 12'(b), 32'hA000_0000 + b);
            #1;
            n_checks++; if (bus.dbg_gnt !== 1'b1) $display("FAIL lock_gnt b%0d: got %0b want 1", b, bus.dbg_gnt); else n_pass++;
            n_checks++; if (bus.core_stall !== 1'b1) $display("FAIL lock_stall b%0d: got %0b want 1", b, bus.core_stall); else n_pass++;
            n_checks++; if (bus.addrb !== 12'(b)) $display("FAIL lock_addrb b%0d: got %h want %h", b, bus.addrb, 12'(b)); else n_pass++;
        end
        @(negedge clk); bus.dbg_req = 1'b0; bus.dbg_lock = 1'b0; #1;
        n_checks++; if (bus.core_stall !== 1'b1) $display("FAIL lock_unlock_stall: got %0b want 1", bus.core_stall); else n_pass++;
        n_checks++; if (bus.enb !== 1'b0) $display("FAIL lock_unlock_idle: got %0b want 0", bus.enb); else n_pass++;
        @(negedge clk); #1;
        n_checks++; if (bus.core_stall !== 1'b0) $display("FAIL lock_core_back_stall: got %0b want 0", bus.core_stall); else n_pass++;
        n_checks++; if (bus.addrb !== 12'd7) $display("FAIL lock_core_back_addrb: got %h want 7", bus.addrb); else n_pass++;
        @(negedge clk); idle(); core_drive(4'h0, 12'd2, 32'h0);
        @(negedge clk); idle(); #1;
        n_checks++; if (bus.core_rvalid !== 1'b1) $display("FAIL lock_readback_rvalid: got %0b want 1", bus.core_rvalid); else n_pass++;
        n_checks++; if (bus.core_rdata !== 32'hA000_0002) $display("FAIL lock_readback_rdata: got %h want a0000002", bus.core_rdata); else n_pass++;
    endtask

    task automatic test_alternating();
        @(negedge clk); core_drive(4'hF, 12'd1, 32'h1111_1111);
        @(negedge clk); core_drive(4'hF, 12'd2, 32'h2222_2222);
        @(negedge clk); core_drive(4'h0, 12'd1, 32'h0);
        @(negedge clk); idle(); dbg_drive(1'b0, 4'h0, 12'd2, 32'h0); #1;
        n_checks++; if (bus.dbg_gnt !== 1'b1) $display("FAIL alt_dbg_gnt: got %0b want 1", bus.dbg_gnt); else n_pass++;
        n_checks++; if (bus.core_rvalid !== 1'b1) $display("FAIL alt_core_rvalid: got %0b want 1", bus.core_rvalid); else n_pass++;
        n_checks++; if (bus.core_rdata !== 32'h1111_1111) $display("FAIL alt_core_rdata: got %h want 11111111", bus.core_rdata); else n_pass++;
        n_checks++; if (bus.dbg_rvalid !== 1'b0) $display("FAIL alt_dbg_rvalid_early: got %0b want 0", bus.dbg_rvalid); else n_pass++;
        n_checks++; if (bus.dbg_rdata !== 32'hDEADBEEF) $display("FAIL alt_dbg_rdata_hold: got %h want deadbeef", bus.dbg_rdata); else n_pass++;
        @(negedge clk); idle(); #1;
        n_checks++; if (bus.dbg_rvalid !== 1'b1) $display("FAIL alt_dbg_rvalid: got %0b want 1", bus.dbg_rvalid); else n_pass++;
        n_checks++; if (bus.dbg_rdata !== 32'h2222_2222) $display("FAIL alt_dbg_rdata: got %h want 22222222", bus.dbg_rdata); else n_pass++;
        n_checks++; if (bus.core_rvalid !== 1'b0) $display("FAIL alt_core_rvalid_late: got %0b want 0", bus.core_rvalid); else n_pass++;
        n_checks++; if (bus.core_rdata !== 32'h1111_1111) $display("FAIL alt_core_rdata_hold: got %h want 11111111", bus.core_rdata); else n_pass++;
    endtask

    task automatic test_byte_enable();
        @(negedge clk); core_drive(4'b0100, 12'd9, 32'h00AB_0000); #1;
        n_checks++; if (bus.web !== 4'b0100) $display("FAIL be_web: got %b want 0100", bus.web); else n_pass++;
        n_checks++; if (bus.dib !== 32'h00AB_0000) $display("FAIL be_dib: got %h want 00ab0000", bus.dib); else n_pass++;
        n_checks++; if (bus.enb !== 1'b1) $display("FAIL be_enb: got %0b want 1", bus.enb); else n_pass++;
        @(negedge clk); idle(); #1;
        n_checks++; if (bus.core_rvalid !== 1'b0) $display("FAIL be_no_rvalid: got %0b want 0", bus.core_rvalid); else n_pass++;
    endtask

    task automatic test_reset_mid_read();
        @(negedge clk); core_drive(4'h0, 12'd1, 32'h0);
        @(posedge clk); #2; rst_n = 1'b0; #1;
        n_checks++; if (bus.core_rvalid !== 1'b0) $display("FAIL rmid_core_rvalid: got %0b want 0", bus.core_rvalid); else n_pass++;
        n_checks++; if (bus.core_rdata !== 32'h0) $display("FAIL rmid_core_rdata: got %h want 0", bus.core_rdata); else n_pass++;
        n_checks++; if (bus.enb !== 1'b0) $display("FAIL rmid_enb: got %0b want 0", bus.enb); else n_pass++;
        n_checks++; if (bus.core_stall !== 1'b0) $display("FAIL rmid_stall: got %0b want 0", bus.core_stall); else n_pass++;
        @(negedge clk); idle(); rst_n = 1'b1; #1;
        n_checks++; if (bus.core_rvalid !== 1'b0) $display("FAIL rmid_core_rvalid_after: got %0b want 0", bus.core_rvalid); else n_pass++;
        @(negedge clk); dbg_drive(1'b1, 4'h0, 12'd2, 32'h0); #1;
        n_checks++; if (bus.dbg_gnt !== 1'b1) $display("FAIL rmid_lock_gnt: got %0b want 1", bus.dbg_gnt); else n_pass++;
        @(posedge clk); #2; rst_n = 1'b0; #1;
        n_checks++; if (bus.dbg_rvalid !== 1'b0) $display("FAIL rmid_dbg_rvalid: got %0b want 0", bus.dbg_rvalid); else n_pass++;
        n_checks++; if (bus.dbg_rdata !== 32'h0) $display("FAIL rmid_dbg_rdata: got %h want 0", bus.dbg_rdata); else n_pass++;
        @(negedge clk); rst_n = 1'b1;
        core_drive(4'hF, 12'd8, 32'h0); dbg_drive(1'b1, 4'hF, 12'd3, 32'h0); #1;
        n_checks++; if (bus.core_stall !== 1'b0) $display("FAIL rmid_state_core_stall: got %0b want 0", bus.core_stall); else n_pass++;
        n_checks++; if (bus.dbg_gnt !== 1'b0) $display("FAIL rmid_state_dbg_gnt: got %0b want 0", bus.dbg_gnt); else n_pass++;
        n_checks++; if (bus.dbg_rvalid !== 1'b0) $display("FAIL rmid_dbg_rvalid_after: got %0b want 0", bus.dbg_rvalid); else n_pass++;
        @(negedge clk); idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_core_only();
        test_contention();
        test_lock_burst();
        test_alternating();
        test_byte_enable();
        test_reset_mid_read();
        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Shares data-BRAM port B between two requesters: the core load/store path (already byte-enabled, aligned `web`/`dib`) and the debug/UART loader.
- Grants one access per cycle, tracks the 1-cycle synchronous BRAM read latency, and returns read data to the owning requester.
- Stalls the core while the loader holds the port.
- Prevents loader starvation with a wait counter.

Parameters:
- ADDR_W, 12, BRAM word-address width.
- MAX_DBG_WAIT, 8, max consecutive cycles a pending debug request may be refused before forced grant (1..255).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- core_req  in  1  core access request (load or store)
- core_we  in  4  core byte write enables (0 = read)
- core_addr  in  ADDR_W  core word address
- core_wdata  in  32  core write data, lane-aligned
- core_stall  out  1  core request not accepted this cycle
- core_rvalid  out  1  core read data valid
- core_rdata  out  32  core read data
- dbg_req  in  1  loader access request
- dbg_lock  in  1  loader holds port across consecutive beats
- dbg_we  in  4  loader byte write enables
- dbg_addr  in  ADDR_W  loader word address
- dbg_wdata  in  32  loader write data
- dbg_gnt  out  1  loader request accepted this cycle
- dbg_rvalid  out  1  loader read data valid
- dbg_rdata  out  32  loader read data
- enb  out  1  BRAM port B enable
- web  out  4  BRAM port B byte write enables
- addrb  out  ADDR_W  BRAM port B address
- dib  out  32  BRAM port B write data
- dob  in  32  BRAM port B read data (1-cycle latency)

Behaviour:
- Reset (async, rst_n=0): state=S_CORE, wait_cnt=0, rd_owner=NONE. All outputs 0. Read-return pipeline cleared.
- States:
  - S_CORE: core has priority.
  - S_DBG: loader locked onto port.
- Grant decision is combinational within the cycle; port B outputs are driven combinationally from the granted requester (`enb`=grant, `web`/`addrb`/`dib` muxed). With no grant, `enb`=0 and `web`=0.
- In S_CORE:
  - core_req=1 and wait_cnt<MAX_DBG_WAIT: grant core.
  - Otherwise, if dbg_req=1: grant loader.
  - Forced grant: dbg_req=1 and wait_cnt==MAX_DBG_WAIT grants the loader even with core_req=1.
  - wait_cnt increments when dbg_req=1 and the loader is not granted (saturates at MAX_DBG_WAIT). It clears on any loader grant or when dbg_req=0.
- Transition S_CORE->S_DBG when the loader is granted with dbg_lock=1.
- In S_DBG:
  - The loader is the only grantee. dbg_gnt=dbg_req.
  - The core is refused. core_stall=core_req.
  - Return to S_CORE the cycle after dbg_lock=0 is sampled.
  - dbg_req may drop while locked; the port idles.
- core_stall = core_req & ~core_gnt.
- dbg_gnt = dbg_req & loader granted.
- Read return:
  - A granted access with we==0 registers the owner (CORE/DBG).
  - Next cycle: owner's rvalid=1 for exactly one cycle, and its rdata=dob.
  - The other requester's rdata holds its previous value.
  - Writes produce no rvalid.
  - Back-to-back reads from alternating owners each return correctly on consecutive cycles.
- Simultaneous first requests in S_CORE with wait_cnt=0: core wins, loader waits.
- Reset asserted mid-read: pending rvalid is discarded. BRAM contents are not the block's concern.
- Core stall while the loader owns the port must hold core inputs stable. The arbiter does not latch core requests.

Decomposition:
- Shared package: owner encoding (NONE=2'd0, CORE=2'd1, DBG=2'd2), state encoding (S_CORE, S_DBG), WE_NONE=4'b0000.
- No sub-module needed; optional tiny `sat_counter` for wait_cnt if reused elsewhere. A single module is preferred.

Test Plan:
- Core-only traffic: core SW 0xDEADBEEF to addr 5, then read addr 5 -> enb=1 web=1111 cycle 0; next read returns core_rvalid=1, core_rdata=0xDEADBEEF one cycle after grant; core_stall=0 throughout.
- Contention with MAX_DBG_WAIT=8: core_req held high, dbg_req asserted at cycle 0 -> dbg_gnt=1 at cycle 8, core_stall=1 that cycle only, wait_cnt back to 0.
- Lock burst: dbg_lock=1, four dbg writes to addr 0..3 -> S_DBG, core_stall=1 for all four beats plus the unlock-sample cycle; core granted first cycle after return to S_CORE.
- Alternating reads: core read addr 1 (0x11111111), loader forced read addr 2 (0x22222222) next cycle -> core_rvalid then dbg_rvalid on consecutive cycles with correct data, no cross-delivery.
- Byte-enable pass-through: core_we=0100, core_wdata=0x00AB0000 -> web=0100, dib=0x00AB0000 same cycle, no rvalid.
- Async reset during pending read: rst_n low between grant and return -> core_rvalid stays 0, all outputs 0, state S_CORE after release.
